// File: rtl/usr_sequencer.sv
// Command sequencer for the 4-bit universal shift register.
// Loads a word, shifts it count times, returns the bits that exit.
module usr_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_fill,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] p_din,
  output logic             s_left_din,
  output logic             s_right_din,
  input  logic             s_left_dout,
  input  logic             s_right_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] data;
  logic             dir;
  logic             fill;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic [WIDTH-1:0] cap;
  logic             exit_bit;
  logic [WIDTH-1:0] cap_next;

  // The bit leaving the register this cycle, before the edge shifts it out
  assign exit_bit = dir ? s_left_dout : s_right_dout;
  assign cap_next = cap | (WIDTH'(exit_bit) << idx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      data        <= '0;
      dir         <= 1'b0;
      fill        <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      cap         <= '0;
      in_ready    <= 1'b1;
      select      <= 2'b00;
      p_din       <= '0;
      s_left_din  <= 1'b0;
      s_right_din <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            data     <= in_data;
            dir      <= in_dir;
            fill     <= in_fill;
            cnt      <= (in_count > MAX_CNT) ? MAX_CNT : in_count;
            idx      <= '0;
            cap      <= '0;
            in_ready <= 1'b0;
            select   <= 2'b11;
            p_din    <= in_data;
            state    <= LOAD;
          end
        end
        LOAD: begin
          p_din <= '0;
          if (cnt != '0) begin
            select      <= dir ? 2'b10 : 2'b01;
            s_left_din  <= dir & fill;
            s_right_din <= ~dir & fill;
            state       <= SHIFT;
          end else begin
            select    <= 2'b00;
            out_valid <= 1'b1;
            out_data  <= cap;
            state     <= DONE;
          end
        end
        SHIFT: begin
          cap <= cap_next;
          idx <= idx + CNT_W'(1);
          if (idx == cnt - CNT_W'(1)) begin
            select      <= 2'b00;
            s_left_din  <= 1'b0;
            s_right_din <= 1'b0;
            out_valid   <= 1'b1;
            out_data    <= cap_next;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usr_sequencer.sv
// Directed bench for usr_sequencer driving a behavioural
// 4-bit universal shift register.
module tb_usr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_dir;
  logic [2:0] in_count;
  logic       in_fill;
  logic [1:0] select;
  logic [3:0] p_din;
  logic       s_left_din;
  logic       s_right_din;
  logic       s_left_dout;
  logic       s_right_dout;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  logic [3:0] q;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] ctl_log[32];
  logic [3:0] pd_log[32];
  int         lat;

  always #5 clk = ~clk;

  usr_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_dir(in_dir),
    .in_count(in_count),
    .in_fill(in_fill),
    .select(select),
    .p_din(p_din),
    .s_left_din(s_left_din),
    .s_right_din(s_right_din),
    .s_left_dout(s_left_dout),
    .s_right_dout(s_right_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data)
  );

  // Downstream universal shift register, sharing rst
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) q <= 4'b0000;
    else begin
      case (select)
        2'b01: q <= {s_right_din, q[3:1]};
        2'b10: q <= {q[2:0], s_left_din};
        2'b11: q <= p_din;
        default: q <= q;
      endcase
    end
  end
  assign s_right_dout = q[0];
  assign s_left_dout  = q[3];

  // Issues one command from a negedge in IDLE; returns at the negedge
  // of the first out_valid cycle, logging {select,sl,sr} per cycle.
  task automatic run_cmd(input logic [3:0] d, input logic dr,
                         input logic [2:0] c, input logic f);
    in_data  = d;
    in_dir   = dr;
    in_count = c;
    in_fill  = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ctl_log[lat] = {select, s_left_din, s_right_din};
      pd_log[lat]  = p_din;
      lat++;
      if (out_valid) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    in_dir = 1'b0;
    in_count = '0;
    in_fill = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, select, p_din, s_left_din, s_right_din,
         out_valid, out_data} !== {1'b1, 2'b00, 4'b0, 1'b0, 1'b0,
         1'b0, 4'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b sel=%b pd=%b sl=%b sr=%b ov=%b od=%b",
               in_ready, select, p_din, s_left_din, s_right_din,
               out_valid, out_data);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_right;
    run_cmd(4'b1011, 1'b0, 3'd2, 1'b1);
    checks++;
    if (lat !== 4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL right_latency: got %0d valid=%b, want 4", lat, out_valid);
    end
    checks++;
    if ({ctl_log[0], ctl_log[1], ctl_log[2], ctl_log[3]} !==
        {4'b1100, 4'b0101, 4'b0101, 4'b0000}) begin
      errors++;
      $display("FAIL right_ctl: got %b %b %b %b, want 1100 0101 0101 0000",
               ctl_log[0], ctl_log[1], ctl_log[2], ctl_log[3]);
    end
    checks++;
    if (pd_log[0] !== 4'b1011 || pd_log[1] !== 4'b0000) begin
      errors++;
      $display("FAIL right_pdin: got %b %b, want 1011 0000",
               pd_log[0], pd_log[1]);
    end
    checks++;
    if (out_data !== 4'b0011 || q !== 4'b1110) begin
      errors++;
      $display("FAIL right_result: got od=%b q=%b, want 0011 1110",
               out_data, q);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL right_idle: got rdy=%b ov=%b, want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_left;
    run_cmd(4'b1011, 1'b1, 3'd3, 1'b0);
    checks++;
    if (lat !== 5 || {ctl_log[0], ctl_log[1], ctl_log[2], ctl_log[3],
        ctl_log[4]} !== {4'b1100, 4'b1000, 4'b1000, 4'b1000, 4'b0000}) begin
      errors++;
      $display("FAIL left_ctl: lat=%0d got %b %b %b %b %b, want 5 1100 1000 1000 1000 0000",
               lat, ctl_log[0], ctl_log[1], ctl_log[2], ctl_log[3], ctl_log[4]);
    end
    checks++;
    if (out_data !== 4'b0101 || q !== 4'b1000) begin
      errors++;
      $display("FAIL left_result: got od=%b q=%b, want 0101 1000",
               out_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_left_fill;
    run_cmd(4'b0010, 1'b1, 3'd2, 1'b1);
    checks++;
    if (ctl_log[1] !== 4'b1010 || out_data !== 4'b0000 || q !== 4'b1011) begin
      errors++;
      $display("FAIL left_fill: got ctl=%b od=%b q=%b, want 1010 0000 1011",
               ctl_log[1], out_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_count;
    run_cmd(4'b0110, 1'b0, 3'd0, 1'b1);
    checks++;
    if (lat !== 2 || out_data !== 4'b0000 || q !== 4'b0110) begin
      errors++;
      $display("FAIL zero_count: got lat=%0d od=%b q=%b, want 2 0000 0110",
               lat, out_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_clamp;
    run_cmd(4'b1010, 1'b0, 3'd7, 1'b0);
    checks++;
    if (lat !== 6 || ctl_log[4] !== 4'b0100 || ctl_log[5] !== 4'b0000) begin
      errors++;
      $display("FAIL clamp_shifts: got lat=%0d ctl4=%b ctl5=%b, want 6 0100 0000",
               lat, ctl_log[4], ctl_log[5]);
    end
    checks++;
    if (out_data !== 4'b1010 || q !== 4'b0000) begin
      errors++;
      $display("FAIL clamp_result: got od=%b q=%b, want 1010 0000",
               out_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    run_cmd(4'b1001, 1'b1, 3'd1, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'b1111;
    in_count = 3'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'b0001 || select !== 2'b00 ||
          in_ready !== 1'b0 || q !== 4'b0011) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ov=%b od=%b sel=%b rdy=%b q=%b, want 1 0001 00 0 0011",
                 i, out_valid, out_data, select, in_ready, q);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || select !== 2'b00) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b ov=%b sel=%b, want 1 0 00",
               in_ready, out_valid, select);
    end
  endtask

  task automatic test_reset_mid_shift;
    in_data  = 4'b1011;
    in_dir   = 1'b0;
    in_count = 3'd3;
    in_fill  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (select !== 2'b00 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        q !== 4'b0000 || out_data !== 4'b0000 || p_din !== 4'b0000 ||
        s_right_din !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sel=%b ov=%b rdy=%b q=%b od=%b pd=%b sr=%b",
               select, out_valid, in_ready, q, out_data, p_din, s_right_din);
    end
    rst = 1'b1;
    @(negedge clk);
    run_cmd(4'b0101, 1'b0, 3'd1, 1'b0);
    checks++;
    if (lat !== 3 || out_data !== 4'b0001 || q !== 4'b0010) begin
      errors++;
      $display("FAIL reset_recover: got lat=%0d od=%b q=%b, want 3 0001 0010",
               lat, out_data, q);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int t1;
    int t2;
    logic [3:0] got1;
    bit seen;
    t2 = -1;
    got1 = 4'bxxxx;
    seen = 1'b0;
    out_ready = 1'b1;
    in_data  = 4'b1100;
    in_dir   = 1'b1;
    in_count = 3'd2;
    in_fill  = 1'b1;
    in_valid = 1'b1;
    t1 = cyc;
    @(posedge clk);
    #1;
    in_data  = 4'b0111;
    in_dir   = 1'b0;
    in_count = 3'd1;
    in_fill  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) got1 = out_data;
      if (in_ready) begin
        t2 = cyc;
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    checks++;
    if (t2 - t1 !== 5 || got1 !== 4'b0011) begin
      errors++;
      $display("FAIL b2b_first: got gap=%0d od=%b, want 5 0011",
               t2 - t1, got1);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || out_data !== 4'b0001 || q !== 4'b0011) begin
      errors++;
      $display("FAIL b2b_second: got seen=%b od=%b q=%b, want 1 0001 0011",
               seen, out_data, q);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_right();
    test_left();
    test_left_fill();
    test_zero_count();
    test_clamp();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
